// File: rtl/key_mem_cmd.sv
// key_mem_cmd: key-driven 8-bit user value with EEPROM save/restore.
//   S1/S2 increment/decrement data_value, wrapping within 0..VAL_MAX.
//   S3 saves data_value and S4 restores it, through a level req / one-cycle
//   ack handshake with a TIMEOUT_MAX-cycle timeout.
// Ports:
//   cmd_clk, cmd_rst      clock, asynchronous active-high reset
//   key_value[3:0]        one-cycle key code (one-hot S1..S4, 4'b1111 none)
//   mem_ack, mem_rd_data  EEPROM completion strobe and read byte
//   wr_req, rd_req        request levels, held until ack or timeout
//   mem_addr, wr_data     EEPROM address (constant) and byte to write
//   data_value            current user value
//   busy, err             transaction outstanding, sticky error
// Optional macro KEY_QUEUE_EN: keeps the most recent S3/S4 that arrives while
// busy and replays it in the first IDLE cycle after the transaction ends.
module key_mem_cmd #(
  parameter logic [7:0]  VAL_MAX     = 8'd99,
  parameter logic [7:0]  INIT_VAL    = 8'd0,
  parameter logic [7:0]  MEM_ADDR    = 8'h00,
  parameter logic [23:0] TIMEOUT_MAX = 24'd5_000_000
) (
  input  logic       cmd_clk,
  input  logic       cmd_rst,
  input  logic [3:0] key_value,
  input  logic       mem_ack,
  input  logic [7:0] mem_rd_data,
  output logic       wr_req,
  output logic       rd_req,
  output logic [7:0] mem_addr,
  output logic [7:0] wr_data,
  output logic [7:0] data_value,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

  localparam logic [3:0] KEY_S1 = 4'b0001;
  localparam logic [3:0] KEY_S2 = 4'b0010;
  localparam logic [3:0] KEY_S3 = 4'b0100;
  localparam logic [3:0] KEY_S4 = 4'b1000;

  state_t      state;
  logic [23:0] tmo_cnt;
  logic [3:0]  key_eff;

  assign mem_addr = MEM_ADDR;

`ifdef KEY_QUEUE_EN
  logic       pend_vld;
  logic [3:0] pend_key;
  logic       pend_vld_next;
  logic [3:0] pend_key_next;
  logic       replay_vld;
  logic [3:0] replay_key;

  // Buffer contents including a save/restore arriving in the current cycle,
  // so a key pressed on the ack cycle itself is not lost.
  always_comb begin
    pend_vld_next = pend_vld;
    pend_key_next = pend_key;
    if (key_value == KEY_S3 || key_value == KEY_S4) begin
      pend_vld_next = 1'b1;
      pend_key_next = key_value;
    end
  end

  // A replayed key takes the place of the live code for its IDLE cycle.
  always_comb begin
    key_eff = key_value;
    if (replay_vld) key_eff = replay_key;
  end
`else
  always_comb begin
    key_eff = key_value;
  end
`endif

  always_ff @(posedge cmd_clk or posedge cmd_rst) begin
    if (cmd_rst) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      data_value <= INIT_VAL;
      wr_data    <= '0;
      wr_req     <= 1'b0;
      rd_req     <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
`ifdef KEY_QUEUE_EN
      pend_vld   <= 1'b0;
      pend_key   <= '0;
      replay_vld <= 1'b0;
      replay_key <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
`ifdef KEY_QUEUE_EN
          replay_vld <= 1'b0;
`endif
          case (key_eff)
            KEY_S1: data_value <= (data_value == VAL_MAX) ? '0 : data_value + 8'd1;
            KEY_S2: data_value <= (data_value == '0) ? VAL_MAX : data_value - 8'd1;
            KEY_S3: begin
              wr_data <= data_value;
              wr_req  <= 1'b1;
              err     <= 1'b0;
              busy    <= 1'b1;
              state   <= WR_WAIT;
            end
            KEY_S4: begin
              rd_req <= 1'b1;
              err    <= 1'b0;
              busy   <= 1'b1;
              state  <= RD_WAIT;
            end
            default: ;
          endcase
        end

        WR_WAIT, RD_WAIT: begin
`ifdef KEY_QUEUE_EN
          pend_vld <= pend_vld_next;
          pend_key <= pend_key_next;
`endif
          if (mem_ack || tmo_cnt == TIMEOUT_MAX - 24'd1) begin
            wr_req  <= 1'b0;
            rd_req  <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
            tmo_cnt <= '0;
`ifdef KEY_QUEUE_EN
            replay_vld <= pend_vld_next;
            replay_key <= pend_key_next;
            pend_vld   <= 1'b0;
`endif
            // Ack has priority over a coincident timeout.
            if (mem_ack) begin
              if (state == RD_WAIT) begin
                if (mem_rd_data <= VAL_MAX) data_value <= mem_rd_data;
                else                        err        <= 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_mem_cmd.sv
module tb_key_mem_cmd;

  logic       cmd_clk;
  logic       cmd_rst;
  logic [3:0] key_value;
  logic       mem_ack;
  logic [7:0] mem_rd_data;
  logic       wr_req;
  logic       rd_req;
  logic [7:0] mem_addr;
  logic [7:0] wr_data;
  logic [7:0] data_value;
  logic       busy;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  key_mem_cmd #(
    .VAL_MAX    (8'd99),
    .INIT_VAL   (8'd0),
    .MEM_ADDR   (8'h00),
    .TIMEOUT_MAX(24'd100)
  ) dut (
    .cmd_clk    (cmd_clk),
    .cmd_rst    (cmd_rst),
    .key_value  (key_value),
    .mem_ack    (mem_ack),
    .mem_rd_data(mem_rd_data),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .mem_addr   (mem_addr),
    .wr_data    (wr_data),
    .data_value (data_value),
    .busy       (busy),
    .err        (err)
  );

  initial cmd_clk = 1'b0;
  always #5 cmd_clk = ~cmd_clk;

  typedef struct {
    logic [3:0] key;
    logic       ack;
    logic [7:0] rd;
    logic [7:0] val;
    logic       wrq;
    logic       rdq;
    logic       bsy;
    logic       er;
    logic [7:0] wd;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drive inputs away from the edge, then sample just after the edge.
  task automatic step(input logic [3:0] k, input logic a, input logic [7:0] d);
    @(negedge cmd_clk);
    key_value   = k;
    mem_ack     = a;
    mem_rd_data = d;
    @(posedge cmd_clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] val, input logic wrq,
                         input logic rdq, input logic bsy, input logic er, input logic [7:0] wd);
    chk({tag, ".data_value"}, 32'(data_value), 32'(val));
    chk({tag, ".wr_req"},     32'(wr_req),     32'(wrq));
    chk({tag, ".rd_req"},     32'(rd_req),     32'(rdq));
    chk({tag, ".busy"},       32'(busy),       32'(bsy));
    chk({tag, ".err"},        32'(err),        32'(er));
    chk({tag, ".wr_data"},    32'(wr_data),    32'(wd));
  endtask

  initial begin
    int n;
    // key, ack, rd_data, exp value, wr_req, rd_req, busy, err, wr_data
    vecs[0]  = '{4'h1, 1'b0, 8'd0,   8'd1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{4'h1, 1'b0, 8'd0,   8'd2,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{4'h1, 1'b0, 8'd0,   8'd3,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{4'hF, 1'b0, 8'd0,   8'd3,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{4'h2, 1'b0, 8'd0,   8'd2,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{4'h2, 1'b0, 8'd0,   8'd1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{4'h2, 1'b0, 8'd0,   8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{4'h2, 1'b0, 8'd0,   8'd99, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{4'h1, 1'b0, 8'd0,   8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{4'h3, 1'b0, 8'd0,   8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{4'h0, 1'b0, 8'd0,   8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{4'hF, 1'b1, 8'd5,   8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[12] = '{4'h8, 1'b0, 8'd0,   8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[13] = '{4'hF, 1'b0, 8'd0,   8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[14] = '{4'hF, 1'b1, 8'd17,  8'd17, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[15] = '{4'h8, 1'b0, 8'd0,   8'd17, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[16] = '{4'h1, 1'b0, 8'd0,   8'd17, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[17] = '{4'hF, 1'b1, 8'd200, 8'd17, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[18] = '{4'h2, 1'b0, 8'd0,   8'd16, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[19] = '{4'h4, 1'b0, 8'd0,   8'd16, 1'b1, 1'b0, 1'b1, 1'b0, 8'd16};
    vecs[20] = '{4'hF, 1'b1, 8'd50,  8'd16, 1'b0, 1'b0, 1'b0, 1'b0, 8'd16};

    cmd_rst     = 1'b1;
    key_value   = 4'hF;
    mem_ack     = 1'b0;
    mem_rd_data = 8'd0;
    repeat (3) @(posedge cmd_clk);
    #1;
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("reset.mem_addr", 32'(mem_addr), 32'h00);
    @(negedge cmd_clk);
    cmd_rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].key, vecs[i].ack, vecs[i].rd);
      chk_all($sformatf("vec%0d", i), vecs[i].val, vecs[i].wrq, vecs[i].rdq,
              vecs[i].bsy, vecs[i].er, vecs[i].wd);
    end

    // Restore 42, then save it with ack ten cycles after the request.
    step(4'h8, 1'b0, 8'd0);
    step(4'hF, 1'b1, 8'd42);
    chk("load42.data_value", 32'(data_value), 32'd42);
    step(4'h4, 1'b0, 8'd0);
    chk_all("save42", 8'd42, 1'b1, 1'b0, 1'b1, 1'b0, 8'd42);
    repeat (9) step(4'hF, 1'b0, 8'd0);
    chk("save42.hold_wr_req", 32'(wr_req), 32'd1);
    step(4'hF, 1'b1, 8'd0);
    chk_all("save42.ack", 8'd42, 1'b0, 1'b0, 1'b0, 1'b0, 8'd42);

    // Save with no ack: request must stay up exactly 100 cycles.
    step(4'h4, 1'b0, 8'd0);
    n = 0;
    while (wr_req === 1'b1 && n < 300) begin
      n++;
      chk("timeout.no_rd_req", 32'(rd_req), 32'd0);
      step(4'hF, 1'b0, 8'd0);
    end
    chk("timeout.cycles", 32'(n), 32'd100);
    chk_all("timeout.end", 8'd42, 1'b0, 1'b0, 1'b0, 1'b1, 8'd42);
    step(4'h8, 1'b0, 8'd0);
    chk_all("s4_clears_err", 8'd42, 1'b0, 1'b1, 1'b1, 1'b0, 8'd42);
    step(4'hF, 1'b1, 8'd7);
    chk("s4_clears_err.load", 32'(data_value), 32'd7);

    // S4 pressed during a save.
    step(4'h4, 1'b0, 8'd0);
    step(4'h8, 1'b0, 8'd0);
    chk("queue.rd_req_while_busy", 32'(rd_req), 32'd0);
    step(4'hF, 1'b1, 8'd0);
    chk("queue.wr_req_fall", 32'(wr_req), 32'd0);
    chk("queue.rd_req_at_fall", 32'(rd_req), 32'd0);
    step(4'hF, 1'b0, 8'd0);
`ifdef KEY_QUEUE_EN
    chk("queue.replayed_rd_req", 32'(rd_req), 32'd1);
    step(4'hF, 1'b1, 8'd11);
    chk("queue.replay_load", 32'(data_value), 32'd11);
`else
    chk("queue.discarded_rd_req", 32'(rd_req), 32'd0);
    step(4'hF, 1'b0, 8'd0);
    chk("queue.discarded_busy", 32'(busy), 32'd0);
`endif

    // Asynchronous reset in the middle of a restore.
    step(4'h8, 1'b0, 8'd0);
    chk("midrst.rd_req_before", 32'(rd_req), 32'd1);
    #2;
    cmd_rst = 1'b1;
    #1;
    chk_all("midrst", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge cmd_clk);
    key_value = 4'hF;
    mem_ack   = 1'b0;
    @(negedge cmd_clk);
    cmd_rst = 1'b0;
    step(4'h1, 1'b0, 8'd0);
    chk("after_rst.inc", 32'(data_value), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
